// File: rtl/depth_stream_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : depth_stream_packer_if
// Description : Pixel beat input and packed-word valid/ready output bundle.
// Revision    : 1.0
// ============================================================================
interface depth_stream_packer_if #(
    parameter int LW = 5
);
    logic          VSYNC;
    logic          HSYNC;
    logic [7:0]    DATA_0;
    logic [7:0]    DATA_1;
    logic          m_valid;
    logic          m_ready;
    logic [31:0]   m_data;
    logic          m_last;
    logic          frame_done;
    logic          overflow;
    logic [LW-1:0] fifo_level;

    modport master (
        input  VSYNC, HSYNC, DATA_0, DATA_1, m_ready,
        output m_valid, m_data, m_last, frame_done, overflow, fifo_level
    );

    modport slave (
        output VSYNC, HSYNC, DATA_0, DATA_1, m_ready,
        input  m_valid, m_data, m_last, frame_done, overflow, fifo_level
    );
endinterface
`default_nettype wire

// File: rtl/depth_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : depth_stream_packer
// Description : Packs 2-pixel beats into 32-bit words, buffers them in a
//               show-ahead FIFO and tags the last word of each frame.
// Revision    : 1.0
// ============================================================================
module depth_stream_packer #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 16,
    parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  wire logic             HCLK,
    input  wire logic             HRESET,
    depth_stream_packer_if.master bus
);
    localparam int c_col_w = $clog2(WIDTH);
    localparam int c_row_w = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int c_aw    = LW - 1;
    localparam logic [c_col_w-1:0] c_col_end = c_col_w'(WIDTH - 2);
    localparam logic [c_row_w-1:0] c_row_end = c_row_w'(HEIGHT - 1);

    logic [c_col_w-1:0] r_col;
    logic [c_row_w-1:0] r_row;
    logic               r_half;
    logic [15:0]        r_lo;
    logic               r_complete;

    logic [32:0]        r_mem [FIFO_DEPTH];
    logic [LW-1:0]      r_wr_ptr;
    logic [LW-1:0]      r_rd_ptr;
    logic               r_overflow;
    logic               r_frame_done;

    logic               w_beat;
    logic               w_row_end;
    logic               w_frame_end;
    logic               w_push;
    logic               w_pop;
    logic               w_wr_en;
    logic               w_empty;
    logic               w_full;
    logic [LW-1:0]      w_level;
    logic [32:0]        w_head;

    assign w_beat      = bus.HSYNC & ~bus.VSYNC & ~r_complete;
    assign w_row_end   = (r_col == c_col_end);
    assign w_frame_end = w_row_end && (r_row == c_row_end);
    // Rows hold a whole number of words, so a row/frame end is always a second half.
    assign w_push      = w_beat & r_half;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_col      <= '0;
            r_row      <= '0;
            r_half     <= 1'b0;
            r_lo       <= '0;
            r_complete <= 1'b0;
        end else if (bus.VSYNC) begin
            r_col      <= '0;
            r_row      <= '0;
            r_half     <= 1'b0;
            r_complete <= 1'b0;
        end else if (w_beat) begin
            r_half <= ~r_half;
            if (!r_half) begin
                r_lo <= {bus.DATA_1, bus.DATA_0};
            end
            if (w_row_end) begin
                r_col <= '0;
                r_row <= r_row + c_row_w'(1);
                if (w_frame_end) begin
                    r_complete <= 1'b1;
                end
            end else begin
                r_col <= r_col + c_col_w'(2);
            end
        end
    end

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (w_level == LW'(FIFO_DEPTH));
    assign w_pop   = ~w_empty & bus.m_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr_en = w_push & (~w_full | w_pop);
    assign w_head  = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge HCLK) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= {w_frame_end, bus.DATA_1, bus.DATA_0, r_lo};
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + LW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LW'(1);
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            r_frame_done <= w_pop & w_head[32];
        end
    end

    assign bus.m_valid    = ~w_empty;
    assign bus.m_data     = w_empty ? 32'd0 : w_head[31:0];
    assign bus.m_last     = ~w_empty & w_head[32];
    assign bus.frame_done = r_frame_done;
    assign bus.overflow   = r_overflow;
    assign bus.fifo_level = w_level;
endmodule
`default_nettype wire

// File: tb/tb_depth_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_depth_stream_packer
// Description : Directed self-checking bench, 8x2 frame, 16-entry FIFO.
// Revision    : 1.0
// ============================================================================
module tb_depth_stream_packer;
    localparam int WIDTH      = 8;
    localparam int HEIGHT     = 2;
    localparam int FIFO_DEPTH = 16;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;

    logic HCLK;
    logic HRESET;
    int   checks;
    int   failures;

    depth_stream_packer_if #(.LW(LW)) bus ();

    depth_stream_packer #(
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LW         (LW)
    ) u_dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic beat(input logic [7:0] d0, input logic [7:0] d1, input logic rdy);
        bus.HSYNC   = 1'b1;
        bus.DATA_0  = d0;
        bus.DATA_1  = d1;
        bus.m_ready = rdy;
        tick();
        bus.HSYNC   = 1'b0;
        bus.m_ready = 1'b0;
    endtask

    task automatic vsync_pulse();
        bus.VSYNC = 1'b1;
        tick();
        bus.VSYNC = 1'b0;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        repeat (3) tick();
        HRESET = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
    endtask

    function automatic logic [31:0] word_of(input int n);
        logic [7:0] b;
        b = 8'(n);
        return {b + 8'hC0, b + 8'h80, b + 8'h40, b};
    endfunction

    // Word n is the ((n-1)%4)-th word of a 4-word frame; frames start with VSYNC.
    task automatic push_word(input int n);
        logic [31:0] w;
        w = word_of(n);
        if ((n - 1) % 4 == 0) vsync_pulse();
        beat(w[7:0], w[15:8], 1'b0);
        beat(w[23:16], w[31:24], 1'b0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 64'(bus.m_valid), 64'd0);
        check({tag, "_data"},  64'(bus.m_data), 64'd0);
        check({tag, "_last"},  64'(bus.m_last), 64'd0);
        check({tag, "_done"},  64'(bus.frame_done), 64'd0);
        check({tag, "_ovf"},   64'(bus.overflow), 64'd0);
        check({tag, "_level"}, 64'(bus.fifo_level), 64'd0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        HRESET      = 1'b1;
        bus.VSYNC   = 1'b0;
        bus.HSYNC   = 1'b0;
        bus.DATA_0  = '0;
        bus.DATA_1  = '0;
        bus.m_ready = 1'b0;

        // Power-on reset
        repeat (3) tick();
        check_idle_outputs("rst");
        HRESET = 1'b0;
        repeat (3) tick();
        check("rst_idle_valid", 64'(bus.m_valid), 64'd0);

        // Packing and one-cycle latency
        vsync_pulse();
        beat(8'h11, 8'h22, 1'b1);
        check("pack_half_valid", 64'(bus.m_valid), 64'd0);
        beat(8'h33, 8'h44, 1'b1);
        check("pack_valid", 64'(bus.m_valid), 64'd1);
        check("pack_data",  64'(bus.m_data), 64'h44332211);
        check("pack_last",  64'(bus.m_last), 64'd0);
        check("pack_level", 64'(bus.fifo_level), 64'd1);
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        check("pack_popped", 64'(bus.m_valid), 64'd0);

        // Frame end: 8 beats -> 4 words, then extra beats ignored
        vsync_pulse();
        for (int i = 0; i < 8; i++) beat(8'(2 * i + 1), 8'(2 * i + 2), 1'b0);
        beat(8'hEE, 8'hEE, 1'b0);
        beat(8'hFF, 8'hFF, 1'b0);
        check("fe_level", 64'(bus.fifo_level), 64'd4);
        tick();
        check("fe_stable", 64'(bus.m_data), 64'h04030201);
        for (int j = 0; j < 4; j++) begin
            logic [31:0] exp_w;
            exp_w = {8'(4 * j + 4), 8'(4 * j + 3), 8'(4 * j + 2), 8'(4 * j + 1)};
            check($sformatf("fe_valid%0d", j), 64'(bus.m_valid), 64'd1);
            check($sformatf("fe_data%0d", j), 64'(bus.m_data), 64'(exp_w));
            check($sformatf("fe_last%0d", j), 64'(bus.m_last), 64'(j == 3));
            pop_one();
            check($sformatf("fe_done%0d", j), 64'(bus.frame_done), 64'(j == 3));
        end
        check("fe_empty", 64'(bus.m_valid), 64'd0);
        tick();
        check("fe_done_pulse", 64'(bus.frame_done), 64'd0);

        // Reset mid-stream with a word queued and a half-word pending
        vsync_pulse();
        beat(8'h01, 8'h02, 1'b0);
        beat(8'h03, 8'h04, 1'b0);
        beat(8'h05, 8'h06, 1'b0);
        check("mid_level", 64'(bus.fifo_level), 64'd1);
        do_reset();
        check_idle_outputs("mid_rst");
        beat(8'h07, 8'h08, 1'b0);
        tick();
        check("mid_no_partial", 64'(bus.m_valid), 64'd0);

        // VSYNC discards a pending half-word
        vsync_pulse();
        beat(8'hAA, 8'hBB, 1'b0);
        vsync_pulse();
        beat(8'h01, 8'h02, 1'b0);
        beat(8'h03, 8'h04, 1'b0);
        check("vs_level", 64'(bus.fifo_level), 64'd1);
        check("vs_data", 64'(bus.m_data), 64'h04030201);
        pop_one();
        check("vs_empty", 64'(bus.m_valid), 64'd0);

        // Backpressure: 17 words into 16 entries
        for (int n = 1; n <= 17; n++) push_word(n);
        check("bp_level", 64'(bus.fifo_level), 64'd16);
        check("bp_ovf", 64'(bus.overflow), 64'd1);
        for (int n = 1; n <= 16; n++) begin
            check($sformatf("bp_data%0d", n), 64'(bus.m_data), 64'(word_of(n)));
            check($sformatf("bp_last%0d", n), 64'(bus.m_last), 64'(n % 4 == 0));
            pop_one();
        end
        check("bp_absent", 64'(bus.m_valid), 64'd0);
        check("bp_ovf_sticky", 64'(bus.overflow), 64'd1);

        // Full FIFO with push and pop in the same cycle
        do_reset();
        for (int n = 1; n <= 16; n++) push_word(n);
        check("fp_level_pre", 64'(bus.fifo_level), 64'd16);
        vsync_pulse();
        beat(8'h5A, 8'h6B, 1'b0);
        beat(8'h7C, 8'h8D, 1'b1);
        check("fp_ovf", 64'(bus.overflow), 64'd0);
        check("fp_level", 64'(bus.fifo_level), 64'd16);
        for (int n = 2; n <= 17; n++) begin
            logic [31:0] exp_w;
            exp_w = (n == 17) ? 32'h8D7C6B5A : word_of(n);
            check($sformatf("fp_data%0d", n), 64'(bus.m_data), 64'(exp_w));
            pop_one();
        end
        check("fp_empty", 64'(bus.m_valid), 64'd0);
        check("fp_level_end", 64'(bus.fifo_level), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/depth_stream_packer.md
# depth_stream_packer

Downstream stage of the stereo depth-map pipeline. Consumes the 2-pixel-per-beat disparity stream (HSYNC-qualified, VSYNC frame-framed) produced by the image reader/matcher. Packs pairs of beats into 32-bit words and buffers them in a show-ahead FIFO. Presents them on a valid/ready master port for the frame writer or memory interface, tagging the last word of each frame.

## Interface
- WIDTH, 320, pixels per row; must be a multiple of 4
- HEIGHT, 240, rows per frame
- FIFO_DEPTH, 16, word entries; power of two, ≥ 2
- LW, $clog2(FIFO_DEPTH)+1, level width (derived)

Ports:
- HCLK  in  1  clock, all logic on rising edge
- HRESET  in  1  reset, asynchronous, active-high
- VSYNC  in  1  frame start; while high, packer row/col/half-word state is cleared
- HSYNC  in  1  beat valid; one beat = two pixels
- DATA_0  in  8  even pixel of beat
- DATA_1  in  8  odd pixel of beat
- m_valid  out  1  FIFO head valid (= not empty)
- m_ready  in  1  downstream accepts head when m_valid & m_ready
- m_data  out  32  packed word at FIFO head
- m_last  out  1  head word is the last word of the frame
- frame_done  out  1  one-cycle pulse after the last word is popped
- overflow  out  1  sticky: a word was dropped because the FIFO was full
- fifo_level  out  LW  entries currently stored, 0..FIFO_DEPTH

## Operation
- Beat accepted when HSYNC=1, VSYNC=0, and frame not yet complete.
- Packing: first beat → bits[7:0]=DATA_0, [15:8]=DATA_1 held in a half-word register; second beat → [23:16]=DATA_0, [31:24]=DATA_1. The full word is pushed on the second beat's edge.
- Position counters: col advances by 2 per accepted beat. At col==WIDTH-2, col wraps to 0 and row increments. WIDTH multiple of 4 ⇒ words never straddle rows.
- Last beat of frame (row==HEIGHT-1, col==WIDTH-2): its word is pushed with last=1. complete flag set; further beats are ignored until VSYNC.
- VSYNC high: clears col, row, half-word, complete. It does not flush the FIFO. VSYNC with HSYNC in the same cycle: VSYNC wins and the beat is dropped.
- FIFO: 33-bit entries {last, data}; show-ahead, so m_data/m_last reflect the head combinationally from storage. Write/read pointers are LW bits wide and wrap naturally.
- Push while full with no pop in the same cycle: word dropped, overflow←1 until HRESET. Push and pop in the same cycle while full: both happen, no overflow, level unchanged. Pop when empty: impossible, since m_valid=0.
- frame_done: registered pulse, high in the cycle after a pop handshake whose m_last=1.

## Timing
- Reset values: m_valid 0, m_data 0 (empty FIFO head reads 0), m_last 0, frame_done 0, overflow 0, fifo_level 0. Pointers, row, col, half-word and complete all clear.
- HRESET asserted mid-frame: immediate clear of all state, with no partial-word output. Operation resumes only after the next VSYNC/beat sequence.
- Latency: second beat sampled at edge N → m_valid=1, m_data valid after edge N (visible in cycle N+1).
- fifo_level updates on the same edge as push/pop: +1 push only, −1 pop only, unchanged for both or neither.
- Throughput: one word per 2 beats in, one word per cycle out. Sustained full-rate HSYNC never overflows while m_ready=1.
- m_data/m_last stable while m_valid=1 and m_ready=0.

## Test plan
- Reset: hold HRESET 3 cycles mid-stream → all outputs 0, fifo_level 0; after release with no beats, m_valid stays 0.
- Packing: VSYNC pulse, beats (0x11,0x22),(0x33,0x44), m_ready=1 → m_data=0x44332211, m_valid=1 in the cycle after the second beat, m_last=0.
- Frame end (WIDTH=8, HEIGHT=2): 8 beats → 4 words; the 4th has m_last=1. frame_done pulses one cycle after the 4th pop. A 9th beat without VSYNC produces nothing.
- Backpressure (FIFO_DEPTH=16): m_ready=0, push 17 words → fifo_level=16, overflow=1. Drain yields words 1..16 in order, and the 17th is absent.
- Full with simultaneous push/pop: level 16, m_ready=1 during a push → overflow stays 0, level stays 16, order preserved.
- VSYNC mid-word: one beat (0xAA,0xBB), then VSYNC, then beats (0x01,0x02),(0x03,0x04) → single word 0x04030201; the 0xAA/0xBB half-word never appears.
